// File: rtl/inv_seg_display.sv
// Display stage for the inventory manager: binary Total -> BCD via a sequential
// double-dabble engine, then a 4-digit multiplexed, active-low seven-segment scan.
module inv_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    input  logic        alarm,
    input  logic        enabled,
    output logic [7:0]  cathode,
    output logic [3:0]  anode,
    output logic        busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [12:0]    shadow_q;
    logic [28:0]    shift_q;
    logic [28:0]    shift_adj;
    logic [28:0]    shift_d;
    logic [3:0]     bit_cnt_q;
    logic [15:0]    bcd_q;
    logic           start;

    logic [RW-1:0]  refresh_cnt_q;
    logic [1:0]     scan_idx_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           blink_phase_q;

    logic [3:0]     upper_zero;
    logic [3:0]     digit_sel;
    logic [6:0]     seg;
    logic           blank;
    logic [7:0]     cathode_q, cathode_d;
    logic [3:0]     anode_q, anode_d;

    assign start = (state_q == ST_IDLE) && (value != shadow_q);

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CONV;
            ST_CONV: if (bit_cnt_q == 4'd12) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == ST_CONV) || (state_q == ST_DONE);
    end

    // Double-dabble: add 3 to each BCD nibble >= 5 before every shift
    assign shift_adj[12:0] = shift_q[12:0];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            logic [3:0] nib;
            assign nib = shift_q[13 + 4*gi +: 4];
            assign shift_adj[13 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate
    assign shift_d = shift_adj << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bcd_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shadow_q  <= value;
                        shift_q   <= {16'b0, value};
                        bit_cnt_q <= '0;
                    end
                end
                ST_CONV: begin
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                ST_DONE: bcd_q <= shift_q[28:13];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= '0;
        end else if (refresh_cnt_q == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= scan_idx_q + 2'd1;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
        end
    end

    // Blink timing only advances while the alarm is up; otherwise it sits at phase 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!alarm) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            assign upper_zero[gi] = ~|bcd_q[15:4*gi];
        end
    endgenerate

    assign digit_sel = bcd_q[{scan_idx_q, 2'b00} +: 4];
    assign blank     = (scan_idx_q != 2'd0) && upper_zero[scan_idx_q];

    always_comb begin
        seg = 7'b1111111;
        case (digit_sel)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    always_comb begin
        anode_d   = ~(4'b0001 << scan_idx_q);
        cathode_d = {1'b1, seg};
        if (alarm && blink_phase_q) begin
            anode_d   = 4'b1111;
            cathode_d = 8'hFF;
        end else if (!enabled) begin
            cathode_d = 8'b10111111;
        end else if (blank) begin
            cathode_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_q   <= 4'b1111;
            cathode_q <= 8'hFF;
        end else begin
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_inv_seg_display.sv
// Self-checking bench for inv_seg_display: every cycle is compared against a
// decimal-arithmetic model of what the display should be showing.
module tb_inv_seg_display;

    localparam int REFRESH = 4;
    localparam int BLINK   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic        alarm;
    logic        enabled;
    logic [7:0]  cathode;
    logic [3:0]  anode;
    logic        busy;

    inv_seg_display #(.REFRESH_DIV(REFRESH), .BLINK_DIV(BLINK)) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .alarm   (alarm),
        .enabled (enabled),
        .cathode (cathode),
        .anode   (anode),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10];
    int         p10 [4];

    // Model state: edges since reset release, conversion bookkeeping, number shown
    int m_edge, m_shadow, m_busy_left, m_pending, m_shown, m_alarm_cnt;
    int busy_seen;
    logic [3:0] exp_an;
    logic [7:0] exp_cath;
    logic       exp_busy;
    bit         exp_forced;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_edge      = 0;
        m_shadow    = 0;
        m_busy_left = 0;
        m_pending   = 0;
        m_shown     = 0;
        m_alarm_cnt = 0;
    endtask

    task automatic tick(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int idx;
            @(posedge clk);
            idx        = (m_edge / REFRESH) % 4;
            exp_forced = alarm && (((m_alarm_cnt / BLINK) % 2) == 1);
            exp_an     = exp_forced ? 4'b1111 : ~(4'b0001 << idx);
            if (!enabled)
                exp_cath = 8'b10111111;
            else if (idx > 0 && m_shown < p10[idx])
                exp_cath = 8'hFF;
            else
                exp_cath = {1'b1, seg_tab[(m_shown / p10[idx]) % 10]};
            m_edge++;
            m_alarm_cnt = alarm ? m_alarm_cnt + 1 : 0;
            if (m_busy_left == 0) begin
                if (int'(value) != m_shadow) begin
                    m_shadow    = int'(value);
                    m_pending   = int'(value);
                    m_busy_left = 14;
                end
            end else begin
                m_busy_left--;
                if (m_busy_left == 0) m_shown = m_pending;
            end
            exp_busy = (m_busy_left != 0);
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
            check("anode", 32'(anode), 32'(exp_an));
            check("busy", 32'(busy), 32'(exp_busy));
            if (!exp_forced) check("cathode", 32'(cathode), 32'(exp_cath));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode"}, 32'(anode), 32'hF);
        check({tag, "_cathode"}, 32'(cathode), 32'hFF);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        p10[0] = 1; p10[1] = 10; p10[2] = 100; p10[3] = 1000;

        // 1. power-on reset, then idle at value 0
        rst = 1'b0; value = 13'd0; enabled = 1'b1; alarm = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("por");
        end
        rst = 1'b1;
        tick(16);

        // 2. conversion latency and scan order for 1234
        value = 13'd1234;
        busy_seen = 0;
        tick(20);
        check("busy_len_1234", 32'(busy_seen), 32'd14);
        tick(32);

        // 3. maximum value and leading-zero blanking
        value = 13'd8191;
        tick(48);
        value = 13'd50;
        tick(48);

        // 4. change during conversion; the later value must win
        value = 13'd100;
        tick(3);
        value = 13'd7;
        busy_seen = 0;
        tick(60);
        check("busy_len_chain", 32'(busy_seen), 32'd25);

        // 5. locked dashes, alarm blink, then recovery
        enabled = 1'b0;
        value   = 13'd1234;
        tick(40);
        alarm = 1'b1;
        tick(80);
        alarm = 1'b0;
        tick(20);
        enabled = 1'b1;
        tick(20);

        // 6. asynchronous reset in the middle of a conversion of 4321
        value = 13'd4321;
        tick(5);
        check("busy_before_rst", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        model_reset();
        busy_seen = 0;
        tick(40);
        check("busy_len_after_rst", 32'(busy_seen), 32'd14);

        // 7. randomized values, lock and alarm toggling against the model
        for (int r = 0; r < 30; r++) begin
            value   = 13'($urandom_range(0, 8191));
            enabled = ($urandom_range(0, 3) != 0);
            alarm   = ($urandom_range(0, 4) == 0);
            tick($urandom_range(1, 40));
        end
        alarm = 1'b0;
        enabled = 1'b1;
        tick(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_seg_display.md
Name: inv_seg_display

Overview:
Downstream display stage of the inventory manager: consumes the 13-bit running Total plus the Alarm and Enabled status, and drives a 4-digit multiplexed seven-segment display.
- Converts binary to BCD with a sequential double-dabble engine.
- Scans the digits with a refresh counter.
- Blanks leading zeros, shows dashes when the system is locked, and blinks while the alarm is active.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (minimum 2)
BLINK_DIV, 25000000, clock cycles per blink half-period while alarm is high (minimum 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
value  input  13  binary quantity to display, 0..8191
alarm  input  1  alarm status from the inventory core
enabled  input  1  1 = authenticated/unlocked, 0 = locked
cathode  output  8  segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
anode  output  4  digit enables, active-low; [0]=ones ... [3]=thousands
busy  output  1  high while a BCD conversion is in progress

Behaviour:
- Reset (rst=0, async): state=IDLE, shadow=0, bcd_digits=0, scan index=0, refresh and blink counters=0, blink phase=0, anode=4'b1111, cathode=8'hFF, busy=0.
- FSM IDLE -> CONV -> DONE -> IDLE:
  - IDLE: if value != shadow at an edge, latch shadow<=value, load shift reg {16'b0,value}, bit count=0, go to CONV, busy<=1.
  - CONV: each edge adds 3 to every BCD nibble >=5, then shifts left 1. After the 13th shift, go to DONE.
  - DONE: bcd_digits<=BCD result, busy<=0, go to IDLE.
  - Total time: the value change is sampled at edge k; digits update at edge k+14; busy is high for edges k..k+13.
- value changes while busy are ignored. The latest value is re-compared in IDLE, so the final value is always displayed eventually.
- value is 13 bits, so the maximum is 8191 and there is no overflow case. The thousands digit never exceeds 8.
- Scan: refresh counter runs 0..REFRESH_DIV-1. On wrap, scan index increments mod 4 (0=ones, 1=tens, 2=hundreds, 3=thousands).
- Outputs are registered and reflect the current index, digits, enabled and alarm with 1-cycle latency.
- Digit decode (gfedcba, active-low, dp always 1):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking: a digit drives cathode=8'hFF if it and all higher digits are 0. The ones digit is never blanked. The anode for the digit is still asserted.
- enabled=0: every scanned digit shows a dash, cathode=8'b10111111. Blanking does not apply. Conversion continues in the background.
- alarm=1:
  - Blink counter runs 0..BLINK_DIV-1 and toggles the phase on wrap.
  - Phase 1 forces anode=4'b1111; phase 0 scans normally.
  - alarm=0 holds the blink counter and phase at 0.
- Priority: reset > alarm blink-off > enabled=0 dashes > normal digits.
- Reset mid-conversion aborts the conversion: busy=0, digits=0, shadow=0. After release, a nonzero value triggers a fresh conversion.

Test Plan:
Bench uses REFRESH_DIV=4 and BLINK_DIV=16.
1. Power-on and idle:
   - Stimulus: hold rst=0.
   - Required: anode=1111, cathode=FF, busy=0.
   - Then release with value=0, enabled=1, alarm=0.
   - Required: index 0 gives anode=1110, cathode=11000000; indices 1..3 give cathode=FF.
2. Conversion latency and scan order:
   - Stimulus: value=1234.
   - Required: busy high for exactly 14 cycles.
   - Required, then cycling every 4 clocks: 1110/10011001, 1101/10110000, 1011/10100100, 0111/11111001.
3. Maximum value and blanking:
   - Stimulus: value=8191.
   - Required: digits 1,9,1,8, with thousands cathode=10000000.
   - Stimulus: value=50.
   - Required: ones=11000000, tens=10010010, hundreds and thousands=FF.
4. Change during conversion:
   - Stimulus: value=100, then value=7 three cycles later.
   - Required: display briefly shows 100, a second busy period follows, and the display finally shows only ones=11111000.
5. Locked and alarm:
   - Stimulus: enabled=0 with value=1234.
   - Required: all four anodes scan with cathode=10111111.
   - Stimulus: alarm=1.
   - Required: anode forced to 1111 for 16 cycles, then scanning for 16 cycles, repeating.
   - Stimulus: alarm=0.
   - Required: normal scan resumes immediately.
6. Reset mid-conversion:
   - Stimulus: rst=0 pulsed 5 cycles into a conversion of 4321.
   - Required: busy=0 and anode=1111 immediately (async).
   - Required after release: a full 14-cycle conversion, then 4321 displayed.
